// File: rtl/rgb_pattern_gen_if.sv
// Pixel bus from the pattern generator to the JPEG encoder input path.
// The generator owns every signal; the encoder only listens.
interface rgb_pattern_gen_if #(
  parameter int unsigned DW = 24
);
  logic          rgb_clk;
  logic          rgb_de;
  logic          rgb_sof;
  logic          rgb_eol;
  logic [DW-1:0] rgb_data;

  modport master (output rgb_clk, rgb_de, rgb_sof, rgb_eol, rgb_data);
  modport slave  (input  rgb_clk, rgb_de, rgb_sof, rgb_eol, rgb_data);
endinterface

// File: rtl/rgb_pattern_gen.sv
// Parametrised RGB test-pattern source: raster counters, IDLE/RUN frame sequencing and
// one output register stage driving the encoder's rgb_* bus.
module rgb_pattern_gen #(
  parameter int unsigned H_ACTIVE = 720,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BLANK  = 10,
  parameter int unsigned V_BLANK  = 1,
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned FRAME_W  = 8,
  parameter int unsigned CHK_LOG2 = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [2:0]           mode,
  input  logic [FRAME_W-1:0]   frames,
  input  logic [3*COLOR_W-1:0] solid_color,
  rgb_pattern_gen_if.master    rgb,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned DW      = 3 * COLOR_W;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned BAR_W   = H_ACTIVE / DW;
  // Guards the divider when the line is narrower than DW; no bar is lit then.
  localparam int unsigned BAR_DIV = (BAR_W == 0) ? 1 : BAR_W;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [HW-1:0] BAR_END    = HW'(DW * BAR_W);
  localparam logic [HW-1:0] BAR_DIV_H  = HW'(BAR_DIV);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [HW-1:0]      h_q, h_d;
  logic [VW-1:0]      v_q, v_d;
  logic [FRAME_W-1:0] frame_idx_q, frame_idx_d;
  logic [FRAME_W-1:0] frames_q, frames_d;
  logic [2:0]         mode_q, mode_d;
  logic [DW-1:0]      color_q, color_d;
  logic               stop_seen_q, stop_seen_d;

  logic               frame_end;
  logic               last_frame;
  logic               de_c;
  logic [DW-1:0]      pix;
  logic [COLOR_W-1:0] h_lo, v_lo, f_lo;
  logic [HW-1:0]      h_sh;
  logic [VW-1:0]      v_sh;

  logic               de_q, sof_q, eol_q;
  logic [DW-1:0]      data_q;

  assign frame_end  = (state_q == StRun) && (h_q == H_LAST) && (v_q == V_LAST);
  assign last_frame = (frames_q != '0) && ((frame_idx_q + FRAME_W'(1)) == frames_q);

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    frame_idx_d = frame_idx_q;
    frames_d    = frames_q;
    mode_d      = mode_q;
    color_d     = color_q;
    stop_seen_d = stop_seen_q;
    frame_done  = 1'b0;

    case (state_q)
      StIdle: begin
        h_d         = '0;
        v_d         = '0;
        frame_idx_d = '0;
        stop_seen_d = 1'b0;
        if (start) begin
          frames_d = frames;
          mode_d   = mode;
          color_d  = solid_color;
          state_d  = StRun;
        end
      end
      default: begin
        if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end else begin
          h_d = h_q + HW'(1);
        end
        stop_seen_d = stop_seen_q | stop;
        if (frame_end) begin
          frame_done  = 1'b1;
          stop_seen_d = 1'b0;
          mode_d      = mode;
          color_d     = solid_color;
          // A stop on this very cycle still ends the frame being finished.
          if (last_frame || stop_seen_q || stop) begin
            state_d     = StIdle;
            frame_idx_d = '0;
          end else begin
            frame_idx_d = frame_idx_q + FRAME_W'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    h_lo = COLOR_W'(h_q);
    v_lo = COLOR_W'(v_q);
    f_lo = COLOR_W'(frame_idx_q);
    h_sh = h_q >> CHK_LOG2;
    v_sh = v_q >> CHK_LOG2;
    pix  = '0;
    case (mode_q)
      3'd0: if (h_q < BAR_END) pix = DW'(1) << (h_q / BAR_DIV_H);
      3'd1: pix = color_q;
      3'd2: pix = {h_lo, h_lo, h_lo};
      3'd3: pix = (h_sh[0] ^ v_sh[0]) ? '1 : '0;
      3'd4: pix = {f_lo, v_lo, h_lo};
      default: pix = '0;
    endcase
  end

  assign de_c = (state_q == StRun) && (h_q < H_ACT) && (v_q < V_ACT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      h_q         <= '0;
      v_q         <= '0;
      frame_idx_q <= '0;
      frames_q    <= '0;
      mode_q      <= '0;
      color_q     <= '0;
      stop_seen_q <= 1'b0;
      de_q        <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      frame_idx_q <= frame_idx_d;
      frames_q    <= frames_d;
      mode_q      <= mode_d;
      color_q     <= color_d;
      stop_seen_q <= stop_seen_d;
      de_q        <= de_c;
      sof_q       <= de_c && (h_q == '0) && (v_q == '0);
      eol_q       <= de_c && (h_q == H_ACT_LAST);
      data_q      <= de_c ? pix : '0;
    end
  end

  assign busy         = (state_q == StRun);
  assign rgb.rgb_clk  = clk;
  assign rgb.rgb_de   = de_q;
  assign rgb.rgb_sof  = sof_q;
  assign rgb.rgb_eol  = eol_q;
  assign rgb.rgb_data = data_q;

endmodule

// File: tb/tb_rgb_pattern_gen.sv
// Self-checking bench for rgb_pattern_gen on a reduced geometry; a raster-time reference
// model predicts every output each cycle, with directed checks on the key scenarios.
module tb_rgb_pattern_gen;

  localparam int unsigned H_ACTIVE = 28;
  localparam int unsigned V_ACTIVE = 10;
  localparam int unsigned H_BLANK  = 3;
  localparam int unsigned V_BLANK  = 2;
  localparam int unsigned COLOR_W  = 4;
  localparam int unsigned FRAME_W  = 4;
  localparam int unsigned CHK_LOG2 = 2;
  localparam int unsigned DW       = 3 * COLOR_W;

  localparam int H_TOTAL   = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL   = V_ACTIVE + V_BLANK;
  localparam int FRAME_CYC = H_TOTAL * V_TOTAL;
  localparam int NPIX      = H_ACTIVE * V_ACTIVE;
  localparam int CMAX      = 1 << COLOR_W;

  logic               clk = 1'b0;
  logic               rst, start, stop;
  logic [2:0]         mode;
  logic [FRAME_W-1:0] frames;
  logic [DW-1:0]      solid_color;
  logic               busy, frame_done;

  rgb_pattern_gen_if #(.DW(DW)) rgb ();

  rgb_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_BLANK  (V_BLANK),
    .COLOR_W  (COLOR_W),
    .FRAME_W  (FRAME_W),
    .CHK_LOG2 (CHK_LOG2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .frames      (frames),
    .solid_color (solid_color),
    .rgb         (rgb),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position inside the run as a linear cycle index within a frame.
  bit m_run = 0, m_stop = 0;
  int m_t = 0, m_frame = 0, m_frames = 0, m_mode = 0, m_color = 0;
  bit e_de, e_sof, e_eol, e_busy, e_done;
  int e_data;

  int de_cnt, done_cnt, done_cyc, start_cyc, pidx, bad;
  int cyc = 0;
  int fbuf [NPIX];
  int sof_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pixel(int md, int col, int h, int v, int f);
    int bw = H_ACTIVE / DW;
    case (md)
      0: return (h >= DW * bw) ? 0 : (1 << (h / bw));
      1: return col;
      2: return (h % CMAX) * (1 + CMAX + CMAX * CMAX);
      3: return ((((h >> CHK_LOG2) ^ (v >> CHK_LOG2)) & 1) != 0) ? (1 << DW) - 1 : 0;
      4: return ((f % CMAX) * CMAX + (v % CMAX)) * CMAX + (h % CMAX);
      default: return 0;
    endcase
  endfunction

  task automatic init_stats();
    de_cnt = 0; done_cnt = 0; done_cyc = -1; pidx = 0;
    sof_q.delete();
  endtask

  task automatic step();
    int h, v;
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_stop = 0; m_t = 0; m_frame = 0;
      e_de = 0; e_sof = 0; e_eol = 0; e_data = 0;
    end else begin
      h = m_t % H_TOTAL;
      v = m_t / H_TOTAL;
      e_de   = m_run && h < H_ACTIVE && v < V_ACTIVE;
      e_sof  = e_de && h == 0 && v == 0;
      e_eol  = e_de && h == H_ACTIVE - 1;
      e_data = e_de ? pixel(m_mode, m_color, h, v, m_frame) : 0;
      if (!m_run) begin
        if (start) begin
          m_run = 1; m_t = 0; m_frame = 0; m_stop = 0;
          m_frames = int'(frames); m_mode = int'(mode); m_color = int'(solid_color);
        end
      end else if (m_t == FRAME_CYC - 1) begin
        if ((m_frames != 0 && m_frame + 1 == m_frames) || m_stop || stop) m_run = 0;
        m_frame = (m_frame + 1) % (1 << FRAME_W);
        m_t = 0; m_stop = 0;
        m_mode = int'(mode); m_color = int'(solid_color);
      end else begin
        m_t++;
        m_stop = m_stop || stop;
      end
    end
    e_busy = m_run;
    e_done = m_run && m_t == FRAME_CYC - 1;
    #1;
    cyc++;
    check("rgb_clk", rgb.rgb_clk, clk);
    check("rgb_de", rgb.rgb_de, e_de);
    check("rgb_sof", rgb.rgb_sof, e_sof);
    check("rgb_eol", rgb.rgb_eol, e_eol);
    check("rgb_data", rgb.rgb_data, e_data);
    check("busy", busy, e_busy);
    check("frame_done", frame_done, e_done);
    if (rgb.rgb_de === 1'b1) begin
      if (rgb.rgb_sof === 1'b1) begin
        pidx = 0;
        sof_q.push_back(int'(rgb.rgb_data));
      end
      if (pidx < NPIX) fbuf[pidx] = int'(rgb.rgb_data);
      pidx++;
      de_cnt++;
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
    end
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (busy !== 1'b0 && n < budget);
    check("idle_reached", busy, 1'b0);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (done_cnt < n && c < budget) begin
      step();
      c++;
    end
    check("frames_reached", done_cnt >= n, 1'b1);
  endtask

  task automatic kick(input int md, input int fr, input int col);
    mode = 3'(md); frames = FRAME_W'(fr); solid_color = DW'(col);
    start = 1'b1;
    step();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = '0; frames = '0; solid_color = '0;
    repeat (3) step();
    rst = 1'b0;
    // Stop and input noise in IDLE must do nothing.
    stop = 1'b1; mode = 3'd4; step(); stop = 1'b0;
    repeat (3) step();
    check("idle_busy", busy, 1'b0);

    // Walking bit, single frame.
    init_stats();
    kick(0, 1, 0);
    check("first_de_early", rgb.rgb_de, 1'b0);
    step();
    check("first_de", rgb.rgb_de, 1'b1);
    check("first_data", rgb.rgb_data, 12'h001);
    check("first_sof", rgb.rgb_sof, 1'b1);
    run_idle(2 * FRAME_CYC);
    check("s1_de_count", de_cnt, NPIX);
    check("s1_done_count", done_cnt, 1);
    check("s1_done_time", done_cyc - start_cyc, FRAME_CYC - 1);
    check("s1_px2", fbuf[2], 12'h002);
    check("s1_px23", fbuf[23], 12'h800);
    check("s1_px24", fbuf[24], 0);
    check("s1_px27", fbuf[27], 0);

    // Three frames of frame tag.
    init_stats();
    kick(4, 3, 0);
    run_idle(4 * FRAME_CYC);
    check("s2_done_count", done_cnt, 3);
    check("s2_sof_count", sof_q.size(), 3);
    foreach (sof_q[i]) check("s2_sof_tag", sof_q[i], i * CMAX * CMAX);

    // Continuous checker, stop in the middle of frame 2.
    init_stats();
    kick(3, 0, 0);
    wait_frames(1, 2 * FRAME_CYC);
    repeat (100) step();
    stop = 1'b1; step(); stop = 1'b0;
    run_idle(2 * FRAME_CYC);
    check("s3_done_count", done_cnt, 2);
    check("s3_de_count", de_cnt, 2 * NPIX);
    repeat (20) step();
    check("s3_no_more_de", de_cnt, 2 * NPIX);
    check("s3_chk_h4v0", fbuf[4], 12'hFFF);
    check("s3_chk_h4v4", fbuf[4 * H_ACTIVE + 4], 0);
    check("s3_chk_h8v0", fbuf[8], 0);

    // Mode/colour change mid frame applies from the next frame.
    init_stats();
    kick(2, 2, 0);
    repeat (50) step();
    mode = 3'd1; solid_color = 12'h123;
    wait_frames(1, 2 * FRAME_CYC);
    bad = 0;
    for (int k = 0; k < NPIX; k++)
      if (fbuf[k] != ((k % H_ACTIVE) % CMAX) * 12'h111) bad++;
    check("s4_ramp_frame", bad, 0);
    run_idle(2 * FRAME_CYC);
    bad = 0;
    for (int k = 0; k < NPIX; k++) if (fbuf[k] != 12'h123) bad++;
    check("s4_solid_frame", bad, 0);

    // Reset mid-line aborts; a stop seen before the reset must not survive it.
    init_stats();
    kick(2, 0, 0);
    repeat (30) step();
    stop = 1'b1; step(); stop = 1'b0;
    repeat (9) step();
    rst = 1'b1; step(); rst = 1'b0;
    check("s5_rst_de", rgb.rgb_de, 1'b0);
    check("s5_rst_data", rgb.rgb_data, 0);
    check("s5_rst_busy", busy, 1'b0);
    init_stats();
    kick(4, 0, 0);
    wait_frames(1, 2 * FRAME_CYC);
    repeat (5) step();
    check("s5_sticky_cleared", busy, 1'b1);
    stop = 1'b1; step(); stop = 1'b0;
    run_idle(2 * FRAME_CYC);
    check("s5_done_count", done_cnt, 2);

    // Stop arriving on the frame-end cycle ends that frame.
    init_stats();
    kick(1, 0, 12'hABC);
    wait_frames(1, 2 * FRAME_CYC);
    stop = 1'b1; step(); stop = 1'b0;
    check("s6_end_stop_busy", busy, 1'b0);
    check("s6_done_count", done_cnt, 1);

    // Start held high re-triggers only from IDLE.
    init_stats();
    mode = 3'd0; frames = 4'd1;
    start = 1'b1;
    step();
    repeat (2 * FRAME_CYC) step();
    check("s7_done_count", done_cnt, 2);
    check("s7_de_count", de_cnt, 2 * NPIX);
    start = 1'b0;
    run_idle(2 * FRAME_CYC);

    // Randomised runs with mid-run input changes and stray stops.
    for (int r = 0; r < 12; r++) begin
      kick($urandom_range(0, 7), $urandom_range(0, 2), $urandom);
      for (int c = 0; c < 4 * FRAME_CYC && busy === 1'b1; c++) begin
        stop = ($urandom_range(0, 299) == 0) || (c == 2 * FRAME_CYC);
        if ($urandom_range(0, 149) == 0) begin
          mode = 3'($urandom_range(0, 7));
          solid_color = DW'($urandom);
        end
        step();
      end
      stop = 1'b0;
      check("rand_idle", busy, 1'b0);
      repeat ($urandom_range(1, 5)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
